// File: rtl/byte_striping_pkg.sv
// Shared striping definitions: lane state encoding and default geometry,
// used by both the striper and the unstriper.
package byte_striping_pkg;

   typedef enum logic [0:0] {
      EVEN = 1'b0,
      ODD  = 1'b1
   } stripe_state_e;

   localparam int unsigned DEF_WIDTH         = 32;
   localparam int unsigned DEF_FLUSH_TIMEOUT = 4;
   localparam int unsigned IDLE_W            = 4;

endpackage

// File: rtl/byte_striping_lane_out_reg.sv
// Output stage for the striper: holds one lane pair (or a lone lane-0 word)
// until downstream consumes it.
module lane_out_reg
   import byte_striping_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic             load,
   input  logic             load_pair,
   input  logic             drain,
   input  logic [WIDTH-1:0] data_0,
   input  logic [WIDTH-1:0] data_1,
   output logic [WIDTH-1:0] lane_0,
   output logic             valid_0,
   output logic [WIDTH-1:0] lane_1,
   output logic             valid_1
);

   // Lane registers: a load wins over a drain; lane_1 keeps its old value on a flush.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         lane_0  <= {WIDTH{1'b0}};
         lane_1  <= {WIDTH{1'b0}};
         valid_0 <= 1'b0;
         valid_1 <= 1'b0;
      end else if (load) begin
         lane_0  <= data_0;
         valid_0 <= 1'b1;
         if (load_pair) begin
            lane_1  <= data_1;
            valid_1 <= 1'b1;
         end else begin
            valid_1 <= 1'b0;
         end
      end else if (drain) begin
         valid_0 <= 1'b0;
         valid_1 <= 1'b0;
      end
   end

endmodule

// File: rtl/byte_striping.sv
// Splits a serial word stream into two lanes: 1st/3rd/... words on lane_0,
// 2nd/4th/... on lane_1, flushing a lone lane-0 word after an idle timeout.
module byte_striping
   import byte_striping_pkg::*;
#(
   parameter int unsigned WIDTH         = DEF_WIDTH,
   parameter int unsigned FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             in_ready,
   output logic [WIDTH-1:0] lane_0,
   output logic             valid_0,
   output logic [WIDTH-1:0] lane_1,
   output logic             valid_1,
   input  logic             lanes_ready,
   output logic [7:0]       pair_count
);

   localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(FLUSH_TIMEOUT);

   stripe_state_e     state_r;
   logic [WIDTH-1:0]  hold_r;
   logic [IDLE_W-1:0] idle_r;
   logic [7:0]        pair_count_r;

   logic pending_s;
   logic out_free_s;
   logic drain_s;
   logic accept_s;
   logic timeout_s;
   logic load_pair_s;
   logic flush_s;
   logic load_s;

   // Handshake and output-stage control decoded from state and backpressure.
   always_comb begin
      pending_s   = valid_0 | valid_1;
      out_free_s  = !pending_s || lanes_ready;
      drain_s     = pending_s && lanes_ready;
      in_ready    = 1'b0;
      if (reset) begin
         in_ready = 1'b0;
      end else begin
         case (state_r)
            EVEN:    in_ready = 1'b1;
            ODD:     in_ready = out_free_s;
            default: in_ready = 1'b0;
         endcase
      end
      accept_s    = valid_in && in_ready;
      timeout_s   = (idle_r == TIMEOUT_C);
      // An arriving word on the timeout cycle forms a pair instead of flushing.
      load_pair_s = (state_r == ODD) && accept_s;
      flush_s     = (state_r == ODD) && !accept_s && timeout_s && out_free_s;
      load_s      = load_pair_s || flush_s;
   end

   // Striping FSM, hold register, idle timer and consumed-transfer counter.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_r      <= EVEN;
         hold_r       <= {WIDTH{1'b0}};
         idle_r       <= {IDLE_W{1'b0}};
         pair_count_r <= 8'd0;
      end else begin
         if (drain_s) begin
            pair_count_r <= pair_count_r + 8'd1;
         end
         case (state_r)
            EVEN: begin
               idle_r <= {IDLE_W{1'b0}};
               if (accept_s) begin
                  hold_r  <= data_in;
                  state_r <= ODD;
               end
            end
            ODD: begin
               if (load_s) begin
                  state_r <= EVEN;
                  idle_r  <= {IDLE_W{1'b0}};
               end else if (!timeout_s) begin
                  idle_r <= idle_r + {{(IDLE_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= EVEN;
               idle_r  <= {IDLE_W{1'b0}};
            end
         endcase
      end
   end

   assign pair_count = pair_count_r;

   lane_out_reg #(
      .WIDTH (WIDTH)
   ) u_lane_out_reg (
      .clk_2f    (clk_2f),
      .reset     (reset),
      .load      (load_s),
      .load_pair (load_pair_s),
      .drain     (drain_s),
      .data_0    (hold_r),
      .data_1    (data_in),
      .lane_0    (lane_0),
      .valid_0   (valid_0),
      .lane_1    (lane_1),
      .valid_1   (valid_1)
   );

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping with hand-computed lane/count expectations.
module tb_byte_striping;

   logic        clk_2f = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_in = 32'h0;
   logic        valid_in = 1'b0;
   logic        in_ready;
   logic [31:0] lane_0;
   logic        valid_0;
   logic [31:0] lane_1;
   logic        valid_1;
   logic        lanes_ready = 1'b0;
   logic [7:0]  pair_count;

   int checks_r = 0;
   int failures_r = 0;

   always #5 clk_2f = ~clk_2f;

   byte_striping #(
      .WIDTH         (32),
      .FLUSH_TIMEOUT (4)
   ) dut (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .in_ready    (in_ready),
      .lane_0      (lane_0),
      .valid_0     (valid_0),
      .lane_1      (lane_1),
      .valid_1     (valid_1),
      .lanes_ready (lanes_ready),
      .pair_count  (pair_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      if (obs !== exp) begin
         failures_r++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_2f);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid_in = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_in_ready", in_ready, 32'd0);
      cyc();
      cyc();
      check("rst_lane_0", lane_0, 32'h0);
      check("rst_lane_1", lane_1, 32'h0);
      check("rst_valid_0", valid_0, 32'd0);
      check("rst_valid_1", valid_1, 32'd0);
      check("rst_count", pair_count, 32'd0);
      reset = 1'b0;
      #1;
      check("even_in_ready", in_ready, 32'd1);

      // Back-to-back stream, no backpressure
      lanes_ready = 1'b1;
      valid_in = 1'b1;
      data_in = 32'h11111111; cyc();
      data_in = 32'h22222222; cyc();
      check("b2b_p1_l0", lane_0, 32'h11111111);
      check("b2b_p1_l1", lane_1, 32'h22222222);
      check("b2b_p1_v", {valid_0, valid_1}, 32'd3);
      data_in = 32'h33333333; cyc();
      check("b2b_drain_v", {valid_0, valid_1}, 32'd0);
      check("b2b_cnt1", pair_count, 32'd1);
      data_in = 32'h44444444; cyc();
      check("b2b_p2_l0", lane_0, 32'h33333333);
      check("b2b_p2_l1", lane_1, 32'h44444444);
      valid_in = 1'b0;
      cyc();
      check("b2b_cnt2", pair_count, 32'd2);
      check("b2b_l1_retain", lane_1, 32'h44444444);

      // Lone word flushed after the idle timeout
      do_reset();
      lanes_ready = 1'b1;
      valid_in = 1'b1;
      data_in = 32'hA5A5A5A5; cyc();
      valid_in = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("flush_early_v0", valid_0, 32'd0);
      cyc();
      check("flush_l0", lane_0, 32'hA5A5A5A5);
      check("flush_v", {valid_0, valid_1}, 32'd2);
      check("flush_l1_retain", lane_1, 32'h0);
      cyc();
      check("flush_cnt", pair_count, 32'd1);
      check("flush_next_even", in_ready, 32'd1);

      // Backpressure: four words while lanes_ready=0
      do_reset();
      lanes_ready = 1'b0;
      valid_in = 1'b1;
      data_in = 32'hAAAA0001; cyc();
      data_in = 32'hAAAA0002; cyc();
      data_in = 32'hAAAA0003; cyc();
      data_in = 32'hAAAA0004;
      #1;
      check("bp_in_ready0", in_ready, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("bp_hold_l0", lane_0, 32'hAAAA0001);
         check("bp_hold_l1", lane_1, 32'hAAAA0002);
         check("bp_in_ready", in_ready, 32'd0);
      end
      lanes_ready = 1'b1;
      #1;
      check("bp_release_rdy", in_ready, 32'd1);
      cyc();
      check("bp_p2_l0", lane_0, 32'hAAAA0003);
      check("bp_p2_l1", lane_1, 32'hAAAA0004);
      check("bp_p2_v", {valid_0, valid_1}, 32'd3);
      check("bp_cnt1", pair_count, 32'd1);
      valid_in = 1'b0;
      cyc();
      check("bp_cnt2", pair_count, 32'd2);
      check("bp_empty", {valid_0, valid_1}, 32'd0);

      // Second word lands exactly on the timeout cycle
      do_reset();
      lanes_ready = 1'b1;
      valid_in = 1'b1;
      data_in = 32'h0BADF00D; cyc();
      valid_in = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      valid_in = 1'b1;
      data_in = 32'h600DCAFE; cyc();
      check("race_l0", lane_0, 32'h0BADF00D);
      check("race_l1", lane_1, 32'h600DCAFE);
      check("race_v", {valid_0, valid_1}, 32'd3);
      valid_in = 1'b0;
      for (int i = 0; i < 7; i++) cyc();
      check("race_no_flush", valid_0, 32'd0);
      check("race_cnt", pair_count, 32'd1);

      // Reset mid-operation discards hold and pending pair
      do_reset();
      lanes_ready = 1'b0;
      valid_in = 1'b1;
      data_in = 32'h12345678; cyc();
      data_in = 32'h9ABCDEF0; cyc();
      data_in = 32'h0F0F0F0F; cyc();
      valid_in = 1'b0;
      reset = 1'b1;
      cyc();
      check("mid_rst_l0", lane_0, 32'h0);
      check("mid_rst_l1", lane_1, 32'h0);
      check("mid_rst_v", {valid_0, valid_1}, 32'd0);
      check("mid_rst_rdy", in_ready, 32'd0);
      reset = 1'b0;
      lanes_ready = 1'b1;
      valid_in = 1'b1;
      data_in = 32'hCAFE0001; cyc();
      data_in = 32'hCAFE0002; cyc();
      check("post_rst_l0", lane_0, 32'hCAFE0001);
      check("post_rst_l1", lane_1, 32'hCAFE0002);
      valid_in = 1'b0;

      // 300 pairs wrap the counter to 44
      do_reset();
      lanes_ready = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 600; i++) begin
         data_in = 32'(i);
         cyc();
      end
      check("wrap_last_l0", lane_0, 32'd598);
      check("wrap_last_l1", lane_1, 32'd599);
      valid_in = 1'b0;
      cyc();
      check("wrap_cnt", pair_count, 32'd44);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule

// File: doc/byte_striping.md
BYTE_STRIPING -- requirements
Module: byte_striping

Interface
REQ-001 Parameter WIDTH, default 32, lane and input word width in bits.
REQ-002 Parameter FLUSH_TIMEOUT, default 4, idle cycles in ODD before a lone lane-0 word is flushed; legal range 1..15.
REQ-003 clk_2f  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  serial word stream from upstream.
REQ-006 valid_in  input  1  data_in carries a word this cycle.
REQ-007 in_ready  output  1  block accepts data_in this cycle; a transfer occurs when valid_in && in_ready.
REQ-008 lane_0  output  WIDTH  even-numbered word (1st, 3rd, ...) of the stream.
REQ-009 valid_0  output  1  lane_0 holds a word.
REQ-010 lane_1  output  WIDTH  odd-numbered word (2nd, 4th, ...) of the stream.
REQ-011 valid_1  output  1  lane_1 holds a word.
REQ-012 lanes_ready  input  1  downstream consumes the presented lane contents this cycle.
REQ-013 pair_count  output  8  count of lane transfers consumed downstream.

Function
REQ-014 The FSM SHALL have states EVEN (next accepted word belongs to lane 0) and ODD (a lane-0 word sits in an internal hold register).
REQ-015 In EVEN, an accepted word SHALL be stored in the hold register, and the FSM SHALL move to ODD.
REQ-016 In ODD, an accepted word SHALL load lane_0<=hold and lane_1<=data_in, with valid_0=valid_1=1 on the next cycle, and the FSM SHALL return to EVEN.
REQ-017 Latency SHALL be one cycle from acceptance of the second word to the pair appearing on the lanes.
REQ-018 The output stage is pending while valid_0||valid_1; it SHALL hold its contents unchanged until a cycle with lanes_ready=1, after which both valids clear unless reloaded in the same cycle.
REQ-019 in_ready SHALL be 1 in EVEN and, in ODD, SHALL equal (!pending || lanes_ready).
REQ-020 An idle counter SHALL count consecutive ODD cycles without acceptance; it clears on acceptance, on flush and in EVEN.
REQ-021 When the idle counter reaches FLUSH_TIMEOUT and the output stage is free or draining, the block SHALL flush: lane_0<=hold, valid_0=1, valid_1=0, FSM->EVEN.
REQ-022 If a flush is blocked by backpressure, it SHALL fire on the first cycle in which the output stage is free or draining.
REQ-023 If valid_in is accepted in the same cycle the timeout expires, the word SHALL form a pair (REQ-016), and no flush SHALL occur.
REQ-024 lane_1 SHALL retain its previous value when valid_1=0.
REQ-025 pair_count SHALL increment by 1 on each cycle with (valid_0||valid_1)&&lanes_ready, counting paired and flushed transfers alike, and SHALL wrap 255->0.
REQ-026 A word SHALL never be dropped or duplicated under any valid_in/lanes_ready pattern.

Reset
REQ-027 While reset=1 at a clock edge: FSM=EVEN, hold=0, lane_0=0, lane_1=0, valid_0=0, valid_1=0, idle counter=0, pair_count=0.
REQ-028 During reset, in_ready SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard hold and pending lane contents without emitting them.

Structure
REQ-030 State encodings (EVEN, ODD) and the default WIDTH and FLUSH_TIMEOUT values SHALL reside in a shared striping package used by byte_striping and the unstriper.
REQ-031 The output stage SHALL be a sub-module named lane_out_reg holding lane_0/lane_1/valids with load and drain controls.

Verification
REQ-032 Stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back with lanes_ready=1 -> pairs (lane_0,lane_1) = (0x11111111,0x22222222) then (0x33333333,0x44444444), pair_count=2.
REQ-033 Single word 0xA5A5A5A5 followed by idle -> after 4 idle cycles, lane_0=0xA5A5A5A5, valid_0=1, valid_1=0; pair_count=1.
REQ-034 Four words with lanes_ready=0 for 6 cycles -> in_ready=0 in ODD, first pair held stable, no loss; both pairs delivered in order once lanes_ready=1.
REQ-035 Second word arriving on the exact timeout cycle -> a pair is emitted with no flush.
REQ-036 reset asserted while in ODD with a pending pair -> all outputs 0 next cycle; the next stream starts at lane 0.
REQ-037 300 pairs -> pair_count wraps to 44.
